// File: rtl/ioctl_upload_reader.sv
// Answers HPS upload reads (FPGA -> HPS) from a byte-wide core RAM.
// Pauses the core CPU first, then stalls each ioctl_rd across the RAM read latency.
module ioctl_upload_reader #(
  parameter int unsigned AW          = 10,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned INDEX       = 4,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ACK_TIMEOUT = 4095
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_q,
  output logic          busy,
  output logic          timeout_flag
);

  localparam int unsigned XW = 25;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned LW = 2;

  typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_READY, S_FETCH} state_t;

  state_t        state, state_nxt;
  logic [7:0]    din_nxt;
  logic          wait_nxt, preq_nxt, mem_rd_nxt, busy_nxt, tflag_nxt, pending_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic          pending;
  logic [XW-1:0] pend_addr, pend_addr_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [LW-1:0] lat, lat_nxt;

  logic          active, timer_hit, pause_exit, req_any, in_range;
  logic [XW-1:0] req_addr;

  // Request decode; a pending PAUSE-time read is served as if it arrived now
  always_comb begin
    active     = ioctl_upload && (ioctl_index == 8'(INDEX));
    timer_hit  = (timer == TW'(ACK_TIMEOUT - 1));
    pause_exit = pause_ack || timer_hit;
    req_any    = (ioctl_rd && active) || pending;
    req_addr   = pending ? pend_addr : ioctl_addr;
    in_range   = (req_addr < XW'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ioctl_din    <= 8'h00;
      ioctl_wait   <= 1'b0;
      pause_req    <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      pending      <= 1'b0;
      pend_addr    <= '0;
      timer        <= '0;
      lat          <= '0;
    end else begin
      state        <= state_nxt;
      ioctl_din    <= din_nxt;
      ioctl_wait   <= wait_nxt;
      pause_req    <= preq_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_rd       <= mem_rd_nxt;
      busy         <= busy_nxt;
      timeout_flag <= tflag_nxt;
      pending      <= pending_nxt;
      pend_addr    <= pend_addr_nxt;
      timer        <= timer_nxt;
      lat          <= lat_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (active) state_nxt = S_PAUSE;
      S_PAUSE: if (!active) state_nxt = S_IDLE;
               else if (pause_exit) state_nxt = S_READY;
      S_READY: if (!active) state_nxt = S_IDLE;
               else if (req_any && in_range) state_nxt = S_FETCH;
      S_FETCH: if (!active) state_nxt = S_IDLE;
               else if (lat == '0) state_nxt = S_READY;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; dropping active in any busy state aborts to idle outputs
  always_comb begin
    din_nxt       = ioctl_din;
    wait_nxt      = ioctl_wait;
    preq_nxt      = pause_req;
    mem_addr_nxt  = mem_addr;
    mem_rd_nxt    = 1'b0;
    tflag_nxt     = timeout_flag;
    pending_nxt   = pending;
    pend_addr_nxt = pend_addr;
    timer_nxt     = timer;
    lat_nxt       = lat;
    busy_nxt      = (state_nxt != S_IDLE);

    if (state != S_IDLE && !active) begin
      preq_nxt    = 1'b0;
      wait_nxt    = 1'b0;
      pending_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          preq_nxt    = 1'b0;
          wait_nxt    = 1'b0;
          pending_nxt = 1'b0;
          if (active) begin
            preq_nxt  = 1'b1;
            wait_nxt  = 1'b1;
            timer_nxt = '0;
            tflag_nxt = 1'b0;
          end
        end
        S_PAUSE: begin
          timer_nxt = timer + TW'(1);
          if (ioctl_rd) begin
            pending_nxt   = 1'b1;
            pend_addr_nxt = ioctl_addr;
          end
          if (pause_exit) begin
            wait_nxt = pending || ioctl_rd;
            if (!pause_ack) tflag_nxt = 1'b1;
          end
        end
        S_READY: begin
          if (req_any) begin
            pending_nxt = 1'b0;
            if (in_range) begin
              mem_addr_nxt = req_addr[AW-1:0];
              mem_rd_nxt   = 1'b1;
              wait_nxt     = 1'b1;
              lat_nxt      = LW'(RD_LATENCY);
            end else begin
              din_nxt  = 8'hFF;
              wait_nxt = 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (lat == '0) begin
            din_nxt  = mem_q;
            wait_nxt = 1'b0;
          end else begin
            lat_nxt = lat - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
